uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small byte FIFO
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_serial;
    logic             r_done;

    logic w_push;
    logic w_pop;
    logic w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_push    = tx_valid && (r_count != FULL);
    // Pop only on entry to START, and only when a byte was already queued before the edge.
    assign w_pop     = (r_count != '0) &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            // Registered one cycle early so the pulse lands on the last stop cycle.
            r_done <= (r_state == STOP) && (r_cnt == CNT_PRE);
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        r_serial <= 1'b0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_bit    <= '0;
                        r_serial <= r_shift[0];
                        r_state  <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_serial <= 1'b1;
                            r_state  <= STOP;
                        end else begin
                            r_serial <= r_shift[r_bit + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift  <= r_mem[r_rd_ptr];
                            r_serial <= 1'b0;
                            r_state  <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_serial = r_serial;
    assign tx_done   = r_done;
    assign tx_ready  = (r_count != FULL);
    assign tx_busy   = (r_state != IDLE) || (r_count != '0);

endmodule
